// File: rtl/fft_pkg.sv
// Shared definitions for the FFT column sequencer slice.
// Word width and point count, complex word layout, sequencer state encoding,
// and the MAC/lane/phase to output-index mapping used by the capture path.
package fft_pkg;

    localparam int WORD_W = 64;
    localparam int NPTS   = 32;

    // Complex word: real part in the upper half, imaginary part in the lower half.
    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } cword_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        DRAIN,
        UNLOAD
    } state_t;

    // MAC m, lane (0 = lane 1, 1 = lane 2), phase s -> 4m + s + 16*lane.
    // The concatenation is exactly that sum because every field is a power of two.
    function automatic logic [4:0] lane_to_idx(input logic [1:0] m,
                                               input logic       lane,
                                               input logic [1:0] s);
        return {lane, m, s};
    endfunction

endpackage

// File: rtl/fft_issue_pipe.sv
// Delay line that tracks issued MAC phases until their results are due back.
// Latency: LAT cycles; LAT = 0 is a combinational pass-through.
// Backpressure: none; one entry enters per cycle. flush clears every valid bit synchronously.
// Ports: clk, flush (sync clear), issue_valid/issue_sel (entering phase),
//        cap_valid/cap_sel (phase whose MAC results are on the bus this cycle).
module fft_issue_pipe #(
    parameter int LAT = 0
) (
    input  logic       clk,
    input  logic       flush,
    input  logic       issue_valid,
    input  logic [1:0] issue_sel,
    output logic       cap_valid,
    output logic [1:0] cap_sel
);

    generate
        if (LAT == 0) begin : g_pass
            // Clock and flush are meaningless without storage; keep the port list uniform.
            logic unused_pass;
            assign unused_pass = clk ^ flush;
            assign cap_valid   = issue_valid;
            assign cap_sel     = issue_sel;
        end else begin : g_delay
            logic [LAT-1:0] vld_sr;
            logic [1:0]     sel_sr [LAT];

            always_ff @(posedge clk) begin
                if (flush) begin
                    vld_sr <= '0;
                end else begin
                    vld_sr[0] <= issue_valid;
                    for (int i = 1; i < LAT; i++) begin
                        vld_sr[i] <= vld_sr[i-1];
                    end
                end
            end

            // Select bits are only meaningful alongside a valid bit, so no flush needed.
            always_ff @(posedge clk) begin
                sel_sr[0] <= issue_sel;
                for (int i = 1; i < LAT; i++) begin
                    sel_sr[i] <= sel_sr[i-1];
                end
            end

            assign cap_valid = vld_sr[LAT-1];
            assign cap_sel   = sel_sr[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/fft_col_sequencer.sv
// Sequencer for one twiddle-multiply column of the 32-point FFT: buffers 32 words,
// issues 4 phases to the shared MAC datapath, captures results, streams 32 products out.
// Latency: start to done = 69 + MAC_LAT cycles at full rate; in_ready/out_valid stall cleanly.
// Ports: start/busy/done control; in_valid/in_ready/in_data input stream; opnd_bus, mac_sel,
//        mac_issue to the MACs, mac_res back; out_valid/out_ready/out_data/out_idx output stream.
module fft_col_sequencer #(
    parameter int WORD_W  = fft_pkg::WORD_W,
    parameter int NPTS    = fft_pkg::NPTS,
    parameter int MAC_LAT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_W-1:0]      in_data,
    output logic [NPTS*WORD_W-1:0] opnd_bus,
    output logic [1:0]             mac_sel,
    output logic                   mac_issue,
    input  logic [8*WORD_W-1:0]    mac_res,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_W-1:0]      out_data,
    output logic [4:0]             out_idx
);

    import fft_pkg::*;

    state_t            state, state_nxt;
    logic [4:0]        in_cnt;
    logic [1:0]        iss_cnt;
    logic [4:0]        out_cnt;
    logic              done_q;
    logic              cap_valid;
    logic [1:0]        cap_sel;
    logic [WORD_W-1:0] ibuf [NPTS];
    logic [WORD_W-1:0] obuf [NPTS];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (in_valid && in_cnt == 5'd31) state_nxt = ISSUE;
            ISSUE:   if (iss_cnt == 2'd3) state_nxt = (MAC_LAT == 0) ? UNLOAD : DRAIN;
            // Leave on the edge that writes the last phase into the output buffer.
            DRAIN:   if (cap_valid && cap_sel == 2'd3) state_nxt = UNLOAD;
            UNLOAD:  if (out_ready && out_cnt == 5'd31) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = 1'b0;
        in_ready  = 1'b0;
        mac_issue = 1'b0;
        mac_sel   = 2'd0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:    ;
            LOAD:    begin busy = 1'b1; in_ready  = 1'b1; end
            ISSUE:   begin busy = 1'b1; mac_issue = 1'b1; mac_sel = iss_cnt; end
            DRAIN:   busy = 1'b1;
            UNLOAD:  begin busy = 1'b1; out_valid = 1'b1; end
            default: ;
        endcase
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            in_cnt <= 5'd0;
        end else if (state == LOAD && in_valid) begin
            in_cnt <= in_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_cnt <= 2'd0;
        end else if (state == ISSUE) begin
            iss_cnt <= iss_cnt + 2'd1;   // wraps back to 0 after phase 3
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_cnt <= 5'd0;
        end else if (state == UNLOAD && out_ready) begin
            out_cnt <= out_cnt + 5'd1;   // wraps back to 0 after word 31
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state == UNLOAD) && out_ready && (out_cnt == 5'd31);
        end
    end

    assign done = done_q;

    // ---------------- input buffer ----------------
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) begin
            ibuf[in_cnt] <= in_data;
        end
    end

    always_comb begin
        opnd_bus = '0;
        for (int i = 0; i < NPTS; i++) begin
            opnd_bus[i*WORD_W +: WORD_W] = ibuf[i];
        end
    end

    // ---------------- issue tracking and capture ----------------
    fft_issue_pipe #(
        .LAT(MAC_LAT)
    ) u_issue_pipe (
        .clk        (clk),
        .flush      (reset),
        .issue_valid(mac_issue),
        .issue_sel  (mac_sel),
        .cap_valid  (cap_valid),
        .cap_sel    (cap_sel)
    );

    // Even result words are lane 1 of MAC m, odd words lane 2.
    always_ff @(posedge clk) begin
        if (!reset && cap_valid) begin
            for (int m = 0; m < 4; m++) begin
                obuf[lane_to_idx(2'(m), 1'b0, cap_sel)] <= mac_res[(2*m)*WORD_W +: WORD_W];
                obuf[lane_to_idx(2'(m), 1'b1, cap_sel)] <= mac_res[(2*m+1)*WORD_W +: WORD_W];
            end
        end
    end

    assign out_idx  = out_cnt;
    assign out_data = obuf[out_cnt];

endmodule

// File: tb/tb_fft_col_sequencer.sv
// Self-checking bench: three sequencer instances (MAC latency 0, 3, 5), each with a MAC model
// whose result for MAC m / lane / phase s is the operand at that output index xor a per-index salt.
module tb_fft_col_sequencer;

    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        sb [$];
    logic [63:0] ref_in [32];

    logic          rst       [3];
    logic          start     [3];
    logic          busy      [3];
    logic          done      [3];
    logic          in_valid  [3];
    logic          in_ready  [3];
    logic [63:0]   in_data   [3];
    logic [2047:0] opnd_bus  [3];
    logic [1:0]    mac_sel   [3];
    logic          mac_issue [3];
    logic [511:0]  mac_res   [3];
    logic          out_valid [3];
    logic          out_ready [3];
    logic [63:0]   out_data  [3];
    logic [4:0]    out_idx   [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] salt(input int k);
        return {32'h0, 8'(k), 8'h5A, 16'h0};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
        logic [511:0] res_now;
        logic [511:0] stage [0:5];

        // Results are poisoned whenever no phase is being issued.
        always_comb begin
            res_now = {8{64'hDEAD_BEEF_0BAD_F00D}};
            if (mac_issue[g]) begin
                for (int m = 0; m < 4; m++) begin
                    for (int ln = 0; ln < 2; ln++) begin
                        res_now[(2*m+ln)*64 +: 64] =
                            opnd_bus[g][(16*ln + 4*m + int'(mac_sel[g]))*64 +: 64]
                            ^ salt(16*ln + 4*m + int'(mac_sel[g]));
                    end
                end
            end
        end

        always @(posedge clk) begin
            stage[0] <= res_now;
            for (int j = 1; j < 6; j++) stage[j] <= stage[j-1];
        end

        assign mac_res[g] = (L == 0) ? res_now : stage[(L == 0) ? 0 : L-1];

        fft_col_sequencer #(.MAC_LAT(L)) dut (
            .clk      (clk),
            .reset    (rst[g]),
            .start    (start[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .opnd_bus (opnd_bus[g]),
            .mac_sel  (mac_sel[g]),
            .mac_issue(mac_issue[g]),
            .mac_res  (mac_res[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g]),
            .out_idx  (out_idx[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input int i);
        check("rst_busy",      64'(busy[i]),      64'd0);
        check("rst_done",      64'(done[i]),      64'd0);
        check("rst_in_ready",  64'(in_ready[i]),  64'd0);
        check("rst_mac_issue", 64'(mac_issue[i]), 64'd0);
        check("rst_mac_sel",   64'(mac_sel[i]),   64'd0);
        check("rst_out_valid", 64'(out_valid[i]), 64'd0);
        check("rst_out_idx",   64'(out_idx[i]),   64'd0);
    endtask

    // Entered at the negedge of the first LOAD cycle; leaves at the negedge of the first ISSUE cycle.
    task automatic load_words(input int i, input logic [31:0] tagv, input int gap_max, input bit poke);
        for (int k = 0; k < 32; k++) begin
            int gap;
            int w;
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (gap) begin
                in_valid[i] = 1'b0;
                start[i]    = 1'b0;
                @(negedge clk);
            end
            in_valid[i] = 1'b1;
            in_data[i]  = {32'h3f800000 + tagv, 32'(k)};
            start[i]    = poke && (k == 10);
            w = 0;
            while (!in_ready[i] && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) check("load_wait", 64'(in_ready[i]), 64'd1);
            ref_in[k] = in_data[i];
            sb.push_back('{idx: 5'(k), dat: in_data[i] ^ salt(k)});
            @(negedge clk);
        end
        in_valid[i] = 1'b0;
        start[i]    = 1'b0;
    endtask

    // Runs ISSUE/DRAIN/UNLOAD; returns at the negedge of the done cycle.
    task automatic run_rest(input int i, input int lat, input int t0, input int exp_total,
                            input int stall_idx, input int stall_len, input bit poke,
                            input bit junk, input bit b2b);
        int iss = 0;
        int drn = 0;
        int got = 0;
        int c = 0;
        int stall_left = stall_len;
        bit fin = 1'b0;
        exp_t e;
        while (!fin) begin
            start[i]     = 1'b0;
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
            if (mac_issue[i]) begin
                if (iss == 0) check("opnd31_first_issue", opnd_bus[i][31*64 +: 64], ref_in[31]);
                check("mac_sel", 64'(mac_sel[i]), 64'(iss));
                iss++;
                if (junk) begin
                    in_valid[i] = 1'b1;
                    in_data[i]  = 64'hBADB_ADBA_DBAD_BADB;
                end
            end
            if (busy[i] && !mac_issue[i] && !in_ready[i] && !out_valid[i]) drn++;
            if (out_valid[i]) begin
                if (poke && got == 20) start[i] = 1'b1;
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(sb.size()), 64'd1);
                end else if (got == stall_idx && stall_left > 0) begin
                    out_ready[i] = 1'b0;
                    check("stall_idx",  64'(out_idx[i]), 64'(sb[0].idx));
                    check("stall_data", out_data[i],     sb[0].dat);
                    stall_left--;
                end else begin
                    e = sb.pop_front();
                    check("out_idx",  64'(out_idx[i]), 64'(e.idx));
                    check("out_data", out_data[i],     e.dat);
                    got++;
                end
            end
            if (done[i]) begin
                fin = 1'b1;
                check("done_idle",    64'(busy[i]), 64'd0);
                check("words_out",    64'(got),     64'd32);
                check("issue_cycles", 64'(iss),     64'd4);
                check("drain_cycles", 64'(drn),     64'(lat));
                if (exp_total >= 0) check("pass_cycles", 64'(cyc - t0), 64'(exp_total));
                if (b2b) start[i] = 1'b1;
            end else begin
                c++;
                if (c > 600) begin
                    check("done_timeout", 64'(done[i]), 64'd1);
                    fin = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic pass(input int i, input int lat, input logic [31:0] tagv, input int gap_max,
                        input int stall_idx, input int stall_len, input bit poke, input bit junk,
                        input bit b2b, input bit started);
        int t0;
        sb.delete();
        if (!started) start[i] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start[i] = 1'b0;
        check("in_ready_after_start", 64'(in_ready[i]), 64'd1);
        load_words(i, tagv, gap_max, poke);
        run_rest(i, lat, t0, (gap_max == 0 && stall_len == 0) ? 69 + lat : -1,
                 stall_idx, stall_len, poke, junk, b2b);
        if (junk) begin
            for (int k = 0; k < 32; k++) check("opnd_unchanged", opnd_bus[i][k*64 +: 64], ref_in[k]);
        end
        if (!b2b) begin
            @(negedge clk);
            check("done_one_cycle", 64'(done[i]), 64'd0);
            check("idle_after",     64'(busy[i]), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int c;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; in_valid[i] = 1'b0;
            in_data[i] = '0; out_ready[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        for (int i = 0; i < 3; i++) check_reset_vals(i);

        // Full-rate pass, combinational MACs, 69 cycles.
        pass(0, 0, 32'h0, 0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        // MAC latency 3: 3 drain cycles, 72 cycles.
        pass(1, 3, 32'h1, 0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Input gaps and a 10-cycle output stall at index 7.
        pass(1, 3, 32'h2, 5, 7, 10, 1'b0, 1'b0, 1'b0, 1'b0);
        // Stray start in LOAD and UNLOAD, junk input during ISSUE.
        pass(0, 0, 32'h3, 0, -1, 0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset in DRAIN with MAC latency 5, then a clean pass.
        sb.delete();
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        load_words(2, 32'h4, 0, 1'b0);
        c = 0;
        while (!(busy[2] && !mac_issue[2] && !in_ready[2] && !out_valid[2]) && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("reached_drain", 64'(busy[2] && !mac_issue[2] && !in_ready[2] && !out_valid[2]), 64'd1);
        rst[2] = 1'b1;
        @(negedge clk);
        check_reset_vals(2);
        rst[2] = 1'b0;
        pass(2, 5, 32'h5, 0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start in the done cycle: back-to-back passes.
        pass(0, 0, 32'h6, 0, -1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        pass(0, 0, 32'h7, 0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
